// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned DEF_DEPTH  = 8;
  localparam int unsigned DEF_CNT_W  = 4;
  localparam int unsigned DEF_DATA_W = 8;

  // Round-robin successor of idx in a ring of n requesters.
  function automatic int unsigned rr_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority selector: first set request at or after i_base.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_base,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic w_hit;

  // Scan N positions starting at i_base, wrapping; keep the first hit.
  always_comb begin
    w_hit = 1'b0;
    o_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_hit && i_req[(32'(i_base) + k) % N]) begin
        w_hit = 1'b1;
        o_idx = IDX_W'((32'(i_base) + k) % N);
      end
    end
    o_found = w_hit;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO between NUM_REQ requesters,
// with packet locking and occupancy-based overflow protection.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [CNT_W-1:0]            fifo_cnt,
  output logic                        fifo_wr,
  output logic [DATA_W-1:0]           fifo_data_in,
  output logic                        lock_active,
  output logic [$clog2(NUM_REQ)-1:0]  owner_id
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_owner;
  logic              r_wr;
  logic [DATA_W-1:0] r_data;
  logic              r_lock;

  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic [CNT_W:0]    w_occ;
  logic              w_space_ok;
  logic              w_accept;
  logic [IDX_W-1:0]  w_sel;
  logic              w_sel_last;
  logic [DATA_W-1:0] w_sel_data;
  logic [IDX_W-1:0]  w_sel_inc;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_base  (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  // The registered write still in flight counts as occupied; reads are not credited.
  assign w_occ      = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, r_wr};
  assign w_space_ok = w_occ < (CNT_W + 1)'(DEPTH);

  assign w_sel_last = req_last[w_sel];
  assign w_sel_data = req_data[32'(w_sel) * DATA_W +: DATA_W];
  assign w_sel_inc  = IDX_W'(rr_inc(32'(w_sel), NUM_REQ));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next state: lock on a non-final beat, release on the owner's final beat.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_sel_last) w_next_state = LOCKED;
      LOCKED:  if (w_accept &&  w_sel_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Grant decode: round-robin winner when idle, owner only when locked.
  always_comb begin
    req_ready = '0;
    w_accept  = 1'b0;
    w_sel     = r_owner;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_found && w_space_ok) begin
            w_sel    = w_win;
            w_accept = 1'b1;
          end
        end
        LOCKED: begin
          if (req_valid[r_owner] && w_space_ok) w_accept = 1'b1;
        end
        default: ;
      endcase
      if (w_accept) req_ready[w_sel] = 1'b1;
    end
  end

  // Registered FIFO write port, ownership, pointer and lock flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_wr     <= 1'b0;
      r_data   <= '0;
      r_lock   <= 1'b0;
    end else begin
      r_wr   <= w_accept;
      r_lock <= (w_next_state == LOCKED);
      if (w_accept) begin
        r_data  <= w_sel_data;
        r_owner <= w_sel;
        if (w_sel_last) r_rr_ptr <= w_sel_inc;
      end
    end
  end

  assign fifo_wr      = r_wr;
  assign fifo_data_in = r_data;
  assign lock_active  = r_lock;
  assign owner_id     = r_owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle behavioural model plus
// directed scenarios with hand-computed write sequences.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_data_in;
  logic            lock_active;
  logic [1:0]      owner_id;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_cnt     (fifo_cnt),
    .fifo_wr      (fifo_wr),
    .fifo_data_in (fifo_data_in),
    .lock_active  (lock_active),
    .owner_id     (owner_id)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester sources: each queue entry is {last, data}.
  logic [8:0]   srcq[N][$];
  logic [N-1:0] taken = '0;

  // Model of the arbiter's externally visible state.
  int         m_ptr   = 0;
  int         m_owner = 0;
  bit         m_lock  = 0;
  bit         m_wr    = 0;
  logic [7:0] m_data  = '0;
  int         acc_cnt = 0;
  logic [7:0] dut_log[$];
  logic [7:0] mdl_log[$];

  // Sources present a new beat just after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (taken[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (srcq[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = srcq[i][0][8];
        req_data[i*DW +: DW]  = srcq[i][0][7:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
  end

  // Per-cycle comparison against the model, then advance the model by one clock.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int  sel;
    bit  space;
    exp_rdy = '0;
    sel     = -1;
    space   = (int'(fifo_cnt) + int'(m_wr)) < DEPTH;
    if (!rst && space) begin
      if (m_lock) begin
        if (req_valid[m_owner]) sel = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (sel < 0 && req_valid[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
      end
    end
    if (sel >= 0) exp_rdy[sel] = 1'b1;

    chk("req_ready", req_ready, exp_rdy);
    chk("fifo_wr", fifo_wr, m_wr);
    if (m_wr) chk("fifo_data_in", fifo_data_in, m_data);
    chk("lock_active", lock_active, m_lock);
    chk("owner_id", owner_id, m_owner);

    if (fifo_wr === 1'b1) dut_log.push_back(fifo_data_in);
    taken = req_ready & req_valid;
    if (taken != '0) acc_cnt++;

    if (rst) begin
      m_ptr = 0; m_owner = 0; m_lock = 0; m_wr = 0; m_data = '0;
    end else begin
      m_wr = (sel >= 0);
      if (sel >= 0) begin
        m_data  = req_data[sel*DW +: DW];
        m_owner = sel;
        mdl_log.push_back(m_data);
        if (req_last[sel]) begin
          m_lock = 0;
          m_ptr  = (sel + 1) % N;
        end else begin
          m_lock = 1;
        end
      end
    end
  end

  task automatic wait_dut(input string name, input int target);
    int n = 0;
    while (dut_log.size() < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, dut_log.size(), target);
  endtask

  task automatic chk_seq(input string name, input int db, input int mb, input logic [7:0] exp[$]);
    for (int k = 0; k < exp.size(); k++) begin
      chk({name, "_dut"}, dut_log[db + k], exp[k]);
      chk({name, "_model"}, mdl_log[mb + k], exp[k]);
    end
  endtask

  initial begin
    int db, mb, a, n;
    logic [7:0] exp_q[$];

    rst      = 1'b1;
    fifo_cnt = '0;
    for (int i = 0; i < N; i++) begin
      srcq[i].push_back({1'b1, 8'(8'h10 + i)});
      srcq[i].push_back({1'b1, 8'(8'h10 + i)});
    end

    // Reset with every requester valid.
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_wr", fifo_wr, 0);
      chk("rst_data", fifo_data_in, 0);
      chk("rst_lock", lock_active, 0);
      chk("rst_owner", owner_id, 0);
    end

    // Fairness: single-beat traffic from all four.
    @(posedge clk); #1;
    db = dut_log.size(); mb = mdl_log.size();
    rst = 1'b0;
    wait_dut("fair_count", db + 8);
    exp_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13};
    chk_seq("fair", db, mb, exp_q);
    repeat (3) @(negedge clk);

    // Single beat from requester 0.
    @(posedge clk); #1;
    srcq[0].push_back({1'b1, 8'hA5});
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0001);
    @(negedge clk);
    chk("single_wr", fifo_wr, 1);
    chk("single_data", fifo_data_in, 8'hA5);
    @(negedge clk);
    chk("single_wr_once", fifo_wr, 0);
    repeat (2) @(negedge clk);

    // Locked 3-beat packet from requester 1 while 2 and 0 wait.
    @(posedge clk); #1;
    db = dut_log.size(); mb = mdl_log.size();
    srcq[1].push_back({1'b0, 8'h21});
    srcq[1].push_back({1'b0, 8'h22});
    srcq[1].push_back({1'b1, 8'h23});
    srcq[2].push_back({1'b1, 8'h30});
    srcq[0].push_back({1'b1, 8'h31});
    @(negedge clk);
    chk("lock_g1", req_ready, 4'b0010);
    @(negedge clk);
    chk("lock_on", lock_active, 1);
    chk("lock_g2", req_ready, 4'b0010);
    @(negedge clk);
    chk("lock_hold", lock_active, 1);
    chk("lock_g3", req_ready, 4'b0010);
    @(negedge clk);
    chk("lock_off", lock_active, 0);
    chk("lock_next", req_ready, 4'b0100);
    wait_dut("lock_count", db + 5);
    exp_q = {8'h21, 8'h22, 8'h23, 8'h30, 8'h31};
    chk_seq("lock", db, mb, exp_q);
    repeat (2) @(negedge clk);

    // Back-pressure from the occupancy count.
    @(posedge clk); #1;
    db = dut_log.size(); mb = mdl_log.size();
    fifo_cnt = 4'd7;
    srcq[3].push_back({1'b1, 8'h41});
    srcq[0].push_back({1'b1, 8'h42});
    @(negedge clk);
    chk("bp_first", req_ready, 4'b1000);
    @(negedge clk);
    chk("bp_inflight_wr", fifo_wr, 1);
    chk("bp_inflight_ready", req_ready, 0);
    @(posedge clk); #1;
    fifo_cnt = 4'd8;
    repeat (5) begin
      @(negedge clk);
      chk("bp_full_wr", fifo_wr, 0);
      chk("bp_full_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    fifo_cnt = 4'd6;
    @(negedge clk);
    chk("bp_resume", req_ready, 4'b0001);
    @(negedge clk);
    chk("bp_resume_wr", fifo_wr, 1);
    repeat (4) @(negedge clk);
    chk("bp_count", dut_log.size(), db + 2);
    exp_q = {8'h41, 8'h42};
    chk_seq("bp", db, mb, exp_q);

    // Reset in the middle of a 4-beat packet from requester 2.
    @(posedge clk); #1;
    fifo_cnt = '0;
    db = dut_log.size(); mb = mdl_log.size();
    a  = acc_cnt;
    srcq[2].push_back({1'b0, 8'h51});
    srcq[2].push_back({1'b0, 8'h52});
    srcq[2].push_back({1'b0, 8'h53});
    srcq[2].push_back({1'b1, 8'h54});
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (acc_cnt < a + 2 && n < 50);
    chk("mid_two_beats", acc_cnt, a + 2);
    #1;
    rst = 1'b1;
    srcq[0].push_back({1'b1, 8'h60});
    @(negedge clk);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_inflight", fifo_wr, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    srcq[2].delete();
    srcq[2].push_back({1'b0, 8'h51});
    srcq[2].push_back({1'b0, 8'h52});
    srcq[2].push_back({1'b0, 8'h53});
    srcq[2].push_back({1'b1, 8'h54});
    @(negedge clk);
    chk("mid_lock_cleared", lock_active, 0);
    chk("mid_wr_cleared", fifo_wr, 0);
    chk("mid_other_wins", req_ready, 4'b0001);
    wait_dut("mid_count", db + 7);
    exp_q = {8'h51, 8'h52, 8'h60, 8'h51, 8'h52, 8'h53, 8'h54};
    chk_seq("mid", db, mb, exp_q);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
